// File: rtl/sram_pin_responder.sv
// Pin-level 64x8 SRAM responder behind a 4-phase req/ack handshake.
// Optional pointer alias at the top address: define SRAM_RESP_AUTOINC_EN.
module sram_pin_responder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [7:0]        uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state, next;

    logic              req_m, req_s, req_q;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr, eff_addr;
    logic [DATA_W-1:0] rdata, rdata_n;
    logic [DATA_W-1:0] dout_n, oe_n;
    logic              ack_r, busy_r, ack_n, busy_n;
    logic [5:0]        count;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign addr = ui_in[ADDR_W-1:0];

`ifdef SRAM_RESP_AUTOINC_EN
    localparam logic [ADDR_W-1:0] PTR_MAX = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] ptr;

    // Top address aliases the pointer, so the pointer never reaches it.
    assign eff_addr = (addr == '1) ? ptr : addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ACCESS) begin
            ptr <= (eff_addr == PTR_MAX) ? '0 : eff_addr + 1'b1;
        end
    end
`else
    assign eff_addr = addr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
            req_q <= 1'b0;
        end else begin
            req_m <= ui_in[7];
            req_s <= req_m;
            req_q <= req_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (req_s && !req_q && ena) begin
                    next = ACCESS;
                end
            end
            ACCESS: next = ACK;
            ACK: begin
                if (!req_s) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Output values are computed from the next state and then registered.
    always_comb begin
        we_n    = we_q;
        rdata_n = rdata;
        ack_n   = 1'b0;
        busy_n  = 1'b0;
        oe_n    = '0;
        dout_n  = '0;
        if (state == ACCESS) begin
            we_n = ui_in[6];
            if (!ui_in[6]) begin
                rdata_n = mem[eff_addr];
            end
        end
        unique case (next)
            ACCESS: busy_n = 1'b1;
            ACK: begin
                ack_n  = 1'b1;
                busy_n = 1'b1;
                if (!we_n) begin
                    oe_n   = '1;
                    dout_n = rdata_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            rdata   <= '0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            uio_oe  <= '0;
            uio_out <= '0;
            count   <= '0;
        end else begin
            we_q    <= we_n;
            rdata   <= rdata_n;
            ack_r   <= ack_n;
            busy_r  <= busy_n;
            uio_oe  <= oe_n;
            uio_out <= dout_n;
            if (state == ACCESS) begin
                count <= count + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ACCESS && ui_in[6]) begin
            mem[eff_addr] <= uio_in;
        end
    end

    assign uo_out = {count, busy_r, ack_r};

endmodule

// File: tb/tb_sram_pin_responder.sv
// Directed self-checking bench for sram_pin_responder.
// Covers reset, latency, aliasing, ena gating, count wrap, async reset.
module tb_sram_pin_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] rd, oe;
    int         lat;

    sram_pin_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        ui_in = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full handshake; lat counts edges from the first sampling edge.
    task automatic txn(input logic w, input logic [5:0] a,
                       input logic [7:0] d, output logic [7:0] rdv,
                       output logic [7:0] oev, output int latv);
        int gone;
        @(negedge clk);
        ui_in  = {1'b1, w, a};
        uio_in = d;
        latv   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (uo_out[0]) begin
                latv = n;
                break;
            end
        end
        if (latv == 0) check("ack_timeout", 0, 1);
        rdv = uio_out;
        oev = uio_oe;
        @(negedge clk);
        ui_in[7] = 1'b0;
        gone = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (!uo_out[0]) begin
                gone = 1;
                break;
            end
        end
        if (gone == 0) check("release_timeout", 0, 1);
        if (oev == 8'hFF || w) check("oe_release", {24'h0, uio_oe}, 0);
    endtask

    initial begin
        do_reset();
        check("rst_uo", {24'h0, uo_out}, 32'h00);
        check("rst_oe", {24'h0, uio_oe}, 32'h00);
        check("rst_dout", {24'h0, uio_out}, 32'h00);

        txn(1'b1, 6'd5, 8'hA5, rd, oe, lat);
        check("wr_oe", {24'h0, oe}, 32'h00);
        check("wr_dout", {24'h0, rd}, 32'h00);
        txn(1'b0, 6'd5, 8'h00, rd, oe, lat);
        check("rd5_data", {24'h0, rd}, 32'hA5);
        check("rd5_oe", {24'h0, oe}, 32'hFF);
        check("rd5_lat", lat, 4);
        check("cnt2", {26'h0, uo_out[7:2]}, 2);

`ifndef SRAM_RESP_AUTOINC_EN
        txn(1'b1, 6'd0, 8'h11, rd, oe, lat);
        txn(1'b1, 6'd63, 8'h3C, rd, oe, lat);
        txn(1'b0, 6'd0, 8'h00, rd, oe, lat);
        check("rd0", {24'h0, rd}, 32'h11);
        txn(1'b0, 6'd63, 8'h00, rd, oe, lat);
        check("rd63", {24'h0, rd}, 32'h3C);
        check("cnt6", {26'h0, uo_out[7:2]}, 6);

        // Request raised while disabled must never be serviced.
        @(negedge clk);
        ena   = 1'b0;
        ui_in = {1'b1, 1'b0, 6'd5};
        repeat (8) @(negedge clk);
        check("ena0_busy", {31'h0, uo_out[1]}, 0);
        check("ena0_ack", {31'h0, uo_out[0]}, 0);
        check("ena0_cnt", {26'h0, uo_out[7:2]}, 6);
        ena = 1'b1;
        repeat (8) @(negedge clk);
        check("ena1_busy", {31'h0, uo_out[1]}, 0);
        check("ena1_cnt", {26'h0, uo_out[7:2]}, 6);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        txn(1'b0, 6'd5, 8'h00, rd, oe, lat);
        check("rerise_data", {24'h0, rd}, 32'hA5);
        check("cnt7", {26'h0, uo_out[7:2]}, 7);
`endif

        do_reset();
        for (int i = 0; i < 64; i++) begin
            txn(1'b1, 6'(i), 8'(i * 3), rd, oe, lat);
        end
        check("wrap_cnt0", {26'h0, uo_out[7:2]}, 0);
        txn(1'b0, 6'd10, 8'h00, rd, oe, lat);
        check("wrap_rd10", {24'h0, rd}, 32'h1E);
        check("wrap_cnt1", {26'h0, uo_out[7:2]}, 1);

`ifdef SRAM_RESP_AUTOINC_EN
        do_reset();
        txn(1'b1, 6'd61, 8'h01, rd, oe, lat);
        txn(1'b1, 6'h3F, 8'h02, rd, oe, lat);
        txn(1'b1, 6'h3F, 8'h03, rd, oe, lat);
        txn(1'b0, 6'd62, 8'h00, rd, oe, lat);
        check("ai_rd62", {24'h0, rd}, 32'h02);
        txn(1'b0, 6'd0, 8'h00, rd, oe, lat);
        check("ai_rd0", {24'h0, rd}, 32'h03);
        txn(1'b0, 6'd61, 8'h00, rd, oe, lat);
        check("ai_rd61", {24'h0, rd}, 32'h01);
`endif

        // Reset asserted between edges while a read is being acknowledged.
        @(negedge clk);
        ui_in = {1'b1, 1'b0, 6'd10};
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (uo_out[0]) begin
                lat = n;
                break;
            end
        end
        check("mid_ack_seen", {31'h0, uo_out[0]}, 1);
        check("mid_oe_seen", {24'h0, uio_oe}, 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ack", {31'h0, uo_out[0]}, 0);
        check("async_oe", {24'h0, uio_oe}, 32'h00);
        check("async_uo", {24'h0, uo_out}, 32'h00);
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
